// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and instruction-memory geometry.
package imem_loader_pkg;

  // Instruction memory depth in 16-bit words.
  localparam int unsigned ImemWords = 1024;

  // Stream bytes are always 8 bits wide.
  localparam int unsigned ByteW = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLenHi  = 3'd1,
    StLenLo  = 3'd2,
    StDataHi = 3'd3,
    StDataLo = 3'd4,
    StWrite  = 3'd5,
    StDone   = 3'd6,
    StErr    = 3'd7
  } load_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Bundle of the loader's byte-stream handshake, instruction-memory write port
// and CPU status lines. The slave side is the loader itself; the master side
// is the host that feeds the byte stream and watches the status.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);

  logic              start;
  logic [ByteW-1:0]  byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/imem_loader.sv
// Writer side of the CPU instruction memory. Parses a byte stream made of a
// 16-bit big-endian word count followed by big-endian instruction words and
// writes them to consecutive word addresses from 0, holding the CPU until the
// load finishes. All state moves on the falling clock edge, matching the
// pipeline and register file.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = $clog2(ImemWords),
  parameter int unsigned DATA_W = 16
) (
  input logic         clock,
  input logic         reset,
  imem_loader_if.slave bus
);

  localparam int unsigned MaxWords = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  load_state_e       state_q;
  logic [15:0]       count_q;
  logic [ByteW-1:0]  hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              ready_q;
  logic              hold_q;
  logic              done_q;
  logic              error_q;

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  // Handshake qualifier, full length once the low byte arrives, and the
  // end-of-program test used while leaving WRITE.
  always_comb begin
    accept    = bus.byte_valid & ready_q;
    len_full  = {count_q[15:8], bus.byte_in};
    last_word = (16'(addr_q) == (count_q - 16'd1));
  end

  // Load sequencer; every output is a register updated alongside the state.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (bus.start) begin
            state_q <= StLenHi;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            addr_q  <= '0;
          end
        end
        StLenHi: begin
          if (accept) begin
            count_q[15:8] <= bus.byte_in;
            state_q       <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            count_q[7:0] <= bus.byte_in;
            if (len_full == 16'd0) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else if (32'(len_full) > MaxWords) begin
              state_q <= StErr;
              ready_q <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= StDataHi;
              addr_q  <= '0;
            end
          end
        end
        StDataHi: begin
          if (accept) begin
            hi_q    <= bus.byte_in;
            state_q <= StDataLo;
          end
        end
        StDataLo: begin
          if (accept) begin
            wdata_q <= DATA_W'({hi_q, bus.byte_in});
            we_q    <= 1'b1;
            ready_q <= 1'b0;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (last_word) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else begin
            addr_q  <= addr_q + AddrOne;
            ready_q <= 1'b1;
            state_q <= StDataHi;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
